// File: rtl/ff_dram_af_ack_d16.sv
// 16-entry show-ahead FIFO on distributed RAM, with programmable almost-full flags
// and sticky overflow/underflow indicators.
module ff_dram_af_ack_d16 #(
  parameter int         WIDTH    = 72,
  parameter logic [6:0] AF0LIMIT = 7'd2,
  parameter logic [6:0] AF1LIMIT = 7'd2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stb,
  input  logic [WIDTH-1:0] i_data,
  output logic [1:0]       i_af,
  output logic             i_full,
  output logic             i_err,
  output logic             o_stb,
  input  logic             o_ack,
  output logic [WIDTH-1:0] o_data,
  output logic             o_ae,
  output logic             o_err
);

  logic [3:0]       wptr;
  logic [3:0]       rptr;
  logic [4:0]       count;
  logic [WIDTH-1:0] mem [16];
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [6:0]       free;

  // Handshake decode; a pop frees the slot that a same-cycle push reuses when full.
  always_comb begin
    full  = (count == 5'd16);
    empty = (count == 5'd0);
    pop   = o_ack & ~empty;
    push  = i_stb & (~full | pop);
    free  = 7'd16 - {2'b00, count};
  end

  // Pointer, occupancy and sticky error state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= 4'd0;
      rptr  <= 4'd0;
      count <= 5'd0;
      i_err <= 1'b0;
      o_err <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 4'd1;
      if (pop)  rptr <= rptr + 4'd1;
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      if (i_stb & full & ~pop) i_err <= 1'b1;
      if (o_ack & empty)       o_err <= 1'b1;
    end
  end

  // Storage array is deliberately left unreset so it maps onto LUT RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= i_data;
  end

  // Status flags and show-ahead read port.
  always_comb begin
    o_data  = mem[rptr];
    o_stb   = ~empty;
    i_full  = full;
    o_ae    = (count <= 5'd1);
    i_af[0] = (free <= AF0LIMIT);
    i_af[1] = (free <= AF1LIMIT);
  end

endmodule

// File: tb/tb_ff_dram_af_ack_d16.sv
// Randomized bench for ff_dram_af_ack_d16: a queue-based reference model checks two
// instances (default limits, and AF0=4/AF1=1) every cycle.
module tb_ff_dram_af_ack_d16;

  localparam int WIDTH = 72;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_stb;
  logic [WIDTH-1:0] i_data;
  logic             o_ack;

  logic [1:0]       i_af,   i_af2;
  logic             i_full, i_full2;
  logic             i_err,  i_err2;
  logic             o_stb,  o_stb2;
  logic [WIDTH-1:0] o_data, o_data2;
  logic             o_ae,   o_ae2;
  logic             o_err,  o_err2;

  int vectors = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] q [$];
  logic             m_ierr;
  logic             m_oerr;

  always #5 clk = ~clk;

  ff_dram_af_ack_d16 #(.WIDTH(WIDTH), .AF0LIMIT(7'd2), .AF1LIMIT(7'd2)) u_dut (
    .clk(clk), .rst(rst), .i_stb(i_stb), .i_data(i_data), .i_af(i_af),
    .i_full(i_full), .i_err(i_err), .o_stb(o_stb), .o_ack(o_ack),
    .o_data(o_data), .o_ae(o_ae), .o_err(o_err)
  );

  ff_dram_af_ack_d16 #(.WIDTH(WIDTH), .AF0LIMIT(7'd4), .AF1LIMIT(7'd1)) u_dut2 (
    .clk(clk), .rst(rst), .i_stb(i_stb), .i_data(i_data), .i_af(i_af2),
    .i_full(i_full2), .i_err(i_err2), .o_stb(o_stb2), .o_ack(o_ack),
    .o_data(o_data2), .o_ae(o_ae2), .o_err(o_err2)
  );

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic af_exp(input int lim);
    return (16 - q.size()) <= lim;
  endfunction

  task automatic check_all();
    int n = q.size();
    check("o_stb",   o_stb,   n != 0);
    check("i_full",  i_full,  n == 16);
    check("o_ae",    o_ae,    n <= 1);
    check("i_af",    i_af,    {af_exp(2), af_exp(2)});
    check("i_err",   i_err,   m_ierr);
    check("o_err",   o_err,   m_oerr);
    check("i_af2",   i_af2,   {af_exp(1), af_exp(4)});
    check("i_full2", i_full2, n == 16);
    check("o_err2",  o_err2,  m_oerr);
    check("i_err2",  i_err2,  m_ierr);
    if (n != 0) begin
      check("o_data",  o_data,  q[0]);
      check("o_data2", o_data2, q[0]);
    end
  endtask

  // Model: pop is granted when non-empty; push when not full or when a pop frees a slot.
  task automatic model_edge(input logic s, input logic [WIDTH-1:0] d, input logic a);
    int  n    = q.size();
    bit  popd = a && (n > 0);
    bit  pshd = s && ((n < 16) || popd);
    if (s && n == 16 && !popd) m_ierr = 1'b1;
    if (a && n == 0)           m_oerr = 1'b1;
    if (popd) void'(q.pop_front());
    if (pshd) q.push_back(d);
  endtask

  task automatic step(input logic s, input logic [WIDTH-1:0] d, input logic a);
    i_stb  = s;
    i_data = d;
    o_ack  = a;
    @(posedge clk);
    model_edge(s, d, a);
    @(negedge clk);
    check_all();
  endtask

  // Asserted between edges so the asynchronous clear is observed before any clock.
  task automatic do_reset();
    i_stb = 1'b0;
    o_ack = 1'b0;
    #2;
    rst = 1'b1;
    q.delete();
    m_ierr = 1'b0;
    m_oerr = 1'b0;
    #1;
    check_all();
    check("rst_af", i_af, 2'b00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask

  function automatic logic [WIDTH-1:0] rnd_word();
    logic [95:0] w = {$urandom, $urandom, $urandom};
    return w[WIDTH-1:0];
  endfunction

  initial begin
    int pstb;
    int pack;
    rst    = 1'b0;
    i_stb  = 1'b0;
    o_ack  = 1'b0;
    i_data = '0;
    m_ierr = 1'b0;
    m_oerr = 1'b0;
    @(negedge clk);
    do_reset();
    step(1'b0, '0, 1'b0);

    // Single word: visible one cycle after the push, gone after the ack.
    step(1'b1, 72'h11, 1'b0);
    check("push11", o_data, 72'h11);
    step(1'b0, '0, 1'b1);
    check("ack11", o_stb, 1'b0);

    // Fill to 14, then full, then simultaneous push/pop across wrap, then overflow.
    for (int i = 0; i < 14; i++) step(1'b1, 72'h100 + 72'(i), 1'b0);
    check("af14", i_af, 2'b11);
    check("nfull14", i_full, 1'b0);
    for (int i = 14; i < 16; i++) step(1'b1, 72'h100 + 72'(i), 1'b0);
    check("full16", i_full, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 72'h200 + 72'(i), 1'b1);
    check("noerr", i_err, 1'b0);
    step(1'b1, 72'hdead, 1'b0);
    check("ovf", i_err, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
    check("drained", o_stb, 1'b0);

    // Underflow, then reset clears both sticky flags.
    step(1'b0, '0, 1'b1);
    check("unf", o_err, 1'b1);
    step(1'b0, '0, 1'b0);
    do_reset();

    // Second instance: AF0=4, AF1=1.
    for (int i = 0; i < 12; i++) step(1'b1, rnd_word(), 1'b0);
    check("af2_12", i_af2, 2'b01);
    for (int i = 0; i < 3; i++) step(1'b1, rnd_word(), 1'b0);
    check("af2_15", i_af2, 2'b11);
    do_reset();

    // Random phases biased towards filling, draining or balanced traffic.
    pstb = 50;
    pack = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) begin
        pstb = $urandom_range(10, 95);
        pack = $urandom_range(10, 95);
      end
      if ($urandom_range(0, 599) == 0) do_reset();
      else step(($urandom_range(0, 99) < pstb), rnd_word(), ($urandom_range(0, 99) < pack));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
